// File: rtl/audio_pkg.sv
// Shared audio-path definitions: servo state encodings and default FIFO thresholds
// for a 64-word audio FIFO.
package audio_pkg;

    typedef enum logic [1:0] {
        SERVO_OFF   = 2'd0,
        SERVO_ACQ   = 2'd1,
        SERVO_TRACK = 2'd2,
        SERVO_LOCK  = 2'd3
    } servo_state_e;

    localparam int DEF_FILL_W   = 6;
    localparam int DEF_NSTEP    = 2;
    localparam int DEF_EMPTY_TH = 4;
    localparam int DEF_LO_TH    = 16;
    localparam int DEF_HI_TH    = 48;
    localparam int DEF_FULL_TH  = 60;
    localparam int DEF_DWELL    = 256;
    localparam int DEF_LOCK_TKS = 1024;

endpackage

// File: rtl/fifo_rate_servo_frame_counter.sv
// Frame-tick counter with synchronous clear; at MAX it either wraps to zero or sticks.
module frame_counter #(
    parameter int W    = 8,
    parameter int MAX  = 255,
    parameter bit WRAP = 1'b0
) (
    input  logic         sample_clk,
    input  logic         nreset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_r;

    // Count register: clear beats increment, terminal value wraps or saturates.
    always_ff @(posedge sample_clk or negedge nreset) begin
        if (!nreset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc) begin
            if (count_r == MAX_V) begin
                count_r <= WRAP ? {W{1'b0}} : MAX_V;
            end else begin
                count_r <= count_r + W'(1);
            end
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fifo_rate_servo.sv
// DAC master-clock trim servo: turns audio FIFO fill level into a signed trim code
// using an acquire/track/lock state machine, dwell timing and sticky slip flags.
module fifo_rate_servo
    import audio_pkg::*;
#(
    parameter int FILL_W   = DEF_FILL_W,
    parameter int NSTEP    = DEF_NSTEP,
    parameter int EMPTY_TH = DEF_EMPTY_TH,
    parameter int LO_TH    = DEF_LO_TH,
    parameter int HI_TH    = DEF_HI_TH,
    parameter int FULL_TH  = DEF_FULL_TH,
    parameter int DWELL    = DEF_DWELL,
    parameter int LOCK_TKS = DEF_LOCK_TKS,
    localparam int SW      = $clog2(NSTEP + 1) + 1
) (
    input  logic              sample_clk,
    input  logic              nreset,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic [FILL_W-1:0] fill_level,
    input  logic              clear_flags,
    output logic [SW-1:0]     adj_code,
    output logic              adj_hi,
    output logic              adj_lo,
    output logic              nom_is_slow,
    output logic [1:0]        servo_state,
    output logic              servo_locked,
    output logic              slip_hi,
    output logic              slip_lo
);

    localparam int CNT_W  = $clog2(DWELL + 1);
    localparam int LOCK_W = $clog2(LOCK_TKS + 1);

    localparam logic [FILL_W-1:0] EMPTY_V = FILL_W'(EMPTY_TH);
    localparam logic [FILL_W-1:0] LO_V    = FILL_W'(LO_TH);
    localparam logic [FILL_W-1:0] HI_V    = FILL_W'(HI_TH);
    localparam logic [FILL_W-1:0] FULL_V  = FILL_W'(FULL_TH);

    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_TKS - 1);

    localparam logic signed [SW-1:0] ADJ_ZERO = SW'(0);
    localparam logic signed [SW-1:0] ADJ_ONE  = SW'(1);
    localparam logic signed [SW-1:0] ADJ_MAX  = SW'(NSTEP);
    localparam logic signed [SW-1:0] ADJ_MIN  = SW'(-NSTEP);

    if (!(EMPTY_TH >= 0 && EMPTY_TH < LO_TH && LO_TH <= HI_TH && HI_TH < FULL_TH &&
          FULL_TH <= (2 ** FILL_W) - 1 && NSTEP >= 1 && DWELL >= 2)) begin : g_param_check
        $error("fifo_rate_servo: illegal threshold or step parameters");
    end

    servo_state_e           state_r, state_nxt;
    logic signed [SW-1:0]   adj_r, adj_nxt;
    logic                   nom_r, nom_nxt;
    logic                   adj_hi_r, adj_lo_r, locked_r;
    logic                   slip_hi_r, slip_lo_r;
    logic                   set_hi_s, set_lo_s;
    logic                   band_clr_s, band_inc_s, dwell_clr_s, dwell_inc_s, lock_clr_s, lock_inc_s;
    logic [CNT_W-1:0]       band_cnt_s, dwell_cnt_s;
    logic [LOCK_W-1:0]      lock_cnt_s;

    logic                   is_full_s, is_empty_s, in_band_s, above_s, below_s;
    logic signed [SW-1:0]   target_s, toward_s, trim_s;
    logic                   trim_chg_s;

    assign is_full_s  = (fill_level >= FULL_V);
    assign is_empty_s = (fill_level <= EMPTY_V);
    assign above_s    = (fill_level > HI_V);
    assign below_s    = (fill_level < LO_V);
    assign in_band_s  = !above_s && !below_s;

    // ACQUIRE walks toward the learned bias; TRACK nudges by one, clamped at +-NSTEP.
    assign target_s   = nom_r ? ADJ_ONE : ADJ_ZERO;
    assign toward_s   = (adj_r < target_s) ? adj_r + ADJ_ONE :
                        (adj_r > target_s) ? adj_r - ADJ_ONE : adj_r;
    assign trim_s     = (above_s && adj_r != ADJ_MAX) ? adj_r + ADJ_ONE :
                        (below_s && adj_r != ADJ_MIN) ? adj_r - ADJ_ONE : adj_r;
    assign trim_chg_s = (dwell_cnt_s == DWELL_LAST) && (trim_s != adj_r);

    // Next-state, trim and counter-control decisions.
    always_comb begin
        state_nxt   = state_r;
        adj_nxt     = adj_r;
        nom_nxt     = nom_r;
        set_hi_s    = 1'b0;
        set_lo_s    = 1'b0;
        band_clr_s  = 1'b0;
        band_inc_s  = 1'b0;
        dwell_clr_s = 1'b0;
        dwell_inc_s = 1'b0;
        lock_clr_s  = 1'b0;
        lock_inc_s  = 1'b0;
        if (!enable) begin
            state_nxt   = SERVO_OFF;
            adj_nxt     = ADJ_ZERO;
            band_clr_s  = 1'b1;
            dwell_clr_s = 1'b1;
            lock_clr_s  = 1'b1;
        end else begin
            case (state_r)
                SERVO_OFF: begin
                    state_nxt   = SERVO_ACQ;
                    band_clr_s  = 1'b1;
                    dwell_clr_s = 1'b1;
                    lock_clr_s  = 1'b1;
                end
                SERVO_ACQ, SERVO_TRACK, SERVO_LOCK: begin
                    if (!frame_tick) begin
                        state_nxt = state_r;
                    end else if (is_full_s) begin
                        adj_nxt    = ADJ_MAX;
                        set_hi_s   = 1'b1;
                        nom_nxt    = (adj_r <= ADJ_ZERO) ? 1'b1 : nom_r;
                        band_clr_s = 1'b1;
                        state_nxt  = SERVO_ACQ;
                    end else if (is_empty_s) begin
                        adj_nxt    = ADJ_MIN;
                        set_lo_s   = 1'b1;
                        nom_nxt    = (adj_r >= ADJ_ZERO) ? 1'b0 : nom_r;
                        band_clr_s = 1'b1;
                        state_nxt  = SERVO_ACQ;
                    end else if (state_r == SERVO_ACQ) begin
                        if (!in_band_s) begin
                            band_clr_s = 1'b1;
                        end else if (band_cnt_s == DWELL_LAST) begin
                            adj_nxt     = toward_s;
                            state_nxt   = SERVO_TRACK;
                            band_clr_s  = 1'b1;
                            dwell_clr_s = 1'b1;
                            lock_clr_s  = 1'b1;
                        end else begin
                            adj_nxt    = toward_s;
                            band_inc_s = 1'b1;
                        end
                    end else begin
                        dwell_inc_s = 1'b1;
                        if (trim_chg_s) begin
                            adj_nxt    = trim_s;
                            lock_clr_s = 1'b1;
                            state_nxt  = SERVO_TRACK;
                        end else if (state_r == SERVO_TRACK && lock_cnt_s >= LOCK_LAST) begin
                            lock_inc_s = 1'b1;
                            state_nxt  = SERVO_LOCK;
                        end else begin
                            lock_inc_s = 1'b1;
                            state_nxt  = state_r;
                        end
                    end
                end
                default: begin
                    state_nxt = SERVO_OFF;
                    adj_nxt   = ADJ_ZERO;
                end
            endcase
        end
    end

    // State, trim code, bias and sticky slip registers; decoded outputs registered too.
    always_ff @(posedge sample_clk or negedge nreset) begin
        if (!nreset) begin
            state_r   <= SERVO_OFF;
            adj_r     <= ADJ_ZERO;
            nom_r     <= 1'b0;
            adj_hi_r  <= 1'b0;
            adj_lo_r  <= 1'b0;
            locked_r  <= 1'b0;
            slip_hi_r <= 1'b0;
            slip_lo_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            adj_r     <= adj_nxt;
            nom_r     <= nom_nxt;
            adj_hi_r  <= (adj_nxt > ADJ_ZERO);
            adj_lo_r  <= (adj_nxt < ADJ_ZERO);
            locked_r  <= (state_nxt == SERVO_LOCK);
            slip_hi_r <= set_hi_s ? 1'b1 : (clear_flags ? 1'b0 : slip_hi_r);
            slip_lo_r <= set_lo_s ? 1'b1 : (clear_flags ? 1'b0 : slip_lo_r);
        end
    end

    frame_counter #(.W(CNT_W), .MAX(DWELL), .WRAP(1'b0)) u_band_cnt (
        .sample_clk (sample_clk),
        .nreset     (nreset),
        .clr        (band_clr_s),
        .inc        (band_inc_s),
        .count      (band_cnt_s)
    );

    frame_counter #(.W(CNT_W), .MAX(DWELL - 1), .WRAP(1'b1)) u_dwell_cnt (
        .sample_clk (sample_clk),
        .nreset     (nreset),
        .clr        (dwell_clr_s),
        .inc        (dwell_inc_s),
        .count      (dwell_cnt_s)
    );

    frame_counter #(.W(LOCK_W), .MAX(LOCK_TKS), .WRAP(1'b0)) u_lock_cnt (
        .sample_clk (sample_clk),
        .nreset     (nreset),
        .clr        (lock_clr_s),
        .inc        (lock_inc_s),
        .count      (lock_cnt_s)
    );

    assign adj_code     = adj_r;
    assign adj_hi       = adj_hi_r;
    assign adj_lo       = adj_lo_r;
    assign nom_is_slow  = nom_r;
    assign servo_state  = state_r;
    assign servo_locked = locked_r;
    assign slip_hi      = slip_hi_r;
    assign slip_lo      = slip_lo_r;

endmodule

// File: tb/tb_fifo_rate_servo.sv
// Directed bench for fifo_rate_servo with short dwell/lock timing (DWELL=4, LOCK_TKS=8).
module tb_fifo_rate_servo;

    logic       sample_clk = 1'b0;
    logic       nreset;
    logic       enable;
    logic       frame_tick;
    logic [5:0] fill_level;
    logic       clear_flags;
    logic [2:0] adj_code;
    logic       adj_hi;
    logic       adj_lo;
    logic       nom_is_slow;
    logic [1:0] servo_state;
    logic       servo_locked;
    logic       slip_hi;
    logic       slip_lo;

    int checks = 0;
    int errors = 0;

    always #5 sample_clk = ~sample_clk;

    fifo_rate_servo #(
        .FILL_W   (6),
        .NSTEP    (2),
        .DWELL    (4),
        .LOCK_TKS (8)
    ) dut (
        .sample_clk   (sample_clk),
        .nreset       (nreset),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .fill_level   (fill_level),
        .clear_flags  (clear_flags),
        .adj_code     (adj_code),
        .adj_hi       (adj_hi),
        .adj_lo       (adj_lo),
        .nom_is_slow  (nom_is_slow),
        .servo_state  (servo_state),
        .servo_locked (servo_locked),
        .slip_hi      (slip_hi),
        .slip_lo      (slip_lo)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // state, signed trim, lock flag, and trim direction flags together
    task automatic expect_core(input string tag, input int st, input int adj, input int locked);
        check({tag, "/state"}, 32'(servo_state), st);
        check({tag, "/adj"}, 32'($signed(adj_code)), adj);
        check({tag, "/locked"}, 32'(servo_locked), locked);
        check({tag, "/adj_hi"}, 32'(adj_hi), (adj > 0) ? 1 : 0);
        check({tag, "/adj_lo"}, 32'(adj_lo), (adj < 0) ? 1 : 0);
    endtask

    task automatic expect_flags(input string tag, input int nom, input int shi, input int slo);
        check({tag, "/nom"}, 32'(nom_is_slow), nom);
        check({tag, "/slip_hi"}, 32'(slip_hi), shi);
        check({tag, "/slip_lo"}, 32'(slip_lo), slo);
    endtask

    task automatic tick(input logic [5:0] f);
        fill_level = f;
        frame_tick = 1'b1;
        @(posedge sample_clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [5:0] f);
        for (int i = 0; i < n; i++) tick(f);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge sample_clk);
            #1;
        end
    endtask

    initial begin
        nreset      = 1'b1;
        enable      = 1'b0;
        frame_tick  = 1'b0;
        fill_level  = 6'd0;
        clear_flags = 1'b0;
        #1 nreset = 1'b0;
        #1;
        expect_core("reset", 0, 0, 0);
        expect_flags("reset", 0, 0, 0);
        @(posedge sample_clk);
        #1 nreset = 1'b1;
        cycles(1);
        expect_core("off_disabled", 0, 0, 0);

        enable = 1'b1;
        cycles(1);
        expect_core("acquire_entry", 1, 0, 0);

        // full in ACQUIRE forces +2 and learns the slow bias
        tick(6'd62);
        expect_core("acq_full", 1, 2, 0);
        expect_flags("acq_full", 1, 1, 0);
        cycles(3);
        expect_core("no_tick_hold", 1, 2, 0);

        tick(6'd30);
        expect_core("acq_band1", 1, 1, 0);
        ticks(2, 6'd30);
        expect_core("acq_band3", 1, 1, 0);
        tick(6'd30);
        expect_core("acq_to_track", 2, 1, 0);
        ticks(2, 6'd30);
        expect_core("track_band_hold", 2, 1, 0);

        // two more in-band ticks bring the dwell phase back to zero
        ticks(2, 6'd30);
        ticks(3, 6'd50);
        expect_core("track_pre_step", 2, 1, 0);
        tick(6'd50);
        expect_core("track_step_up", 2, 2, 0);

        ticks(7, 6'd50);
        expect_core("sat_not_locked", 2, 2, 0);
        tick(6'd50);
        expect_core("sat_locked", 3, 2, 1);

        ticks(3, 6'd10);
        expect_core("locked_pre_step", 3, 2, 1);
        tick(6'd10);
        expect_core("lock_drop_plus1", 2, 1, 0);
        ticks(4, 6'd10);
        expect_core("track_to_zero", 2, 0, 0);

        ticks(7, 6'd30);
        expect_core("relock_pending", 2, 0, 0);
        tick(6'd30);
        expect_core("relock_zero", 3, 0, 1);

        ticks(4, 6'd10);
        expect_core("lock_loss", 2, -1, 0);

        ticks(4, 6'd50);
        expect_core("back_to_zero", 2, 0, 0);
        ticks(8, 6'd30);
        expect_core("relock_again", 3, 0, 1);

        // empty plus clear_flags in the same cycle: the new slip wins, old one clears
        clear_flags = 1'b1;
        tick(6'd3);
        clear_flags = 1'b0;
        expect_core("locked_empty", 1, -2, 0);
        expect_flags("locked_empty", 0, 0, 1);

        tick(6'd30);
        expect_core("acq_toward_zero1", 1, -1, 0);
        tick(6'd30);
        expect_core("acq_toward_zero2", 1, 0, 0);
        ticks(2, 6'd30);
        expect_core("acq_to_track2", 2, 0, 0);
        ticks(4, 6'd50);
        expect_core("track_step2", 2, 1, 0);

        enable = 1'b0;
        cycles(1);
        expect_core("disable", 0, 0, 0);
        expect_flags("disable", 0, 0, 1);
        enable = 1'b1;
        cycles(1);
        expect_core("reenable", 1, 0, 0);

        tick(6'd62);
        expect_core("reacq_full", 1, 2, 0);
        expect_flags("reacq_full", 1, 1, 1);

        // asynchronous reset between clock edges
        #3 nreset = 1'b0;
        #1;
        expect_core("async_reset", 0, 0, 0);
        expect_flags("async_reset", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
